// File: rtl/i2c_wb_sequencer.sv
// Drives an OpenCores-style I2C master over Wishbone: prescale/enable init, then one register write or read per request.
// Each core access holds cyc/stb until ack, followed by one idle cycle; req_i is ignored while busy_o=1.
module i2c_wb_sequencer #(
  parameter logic [15:0] PRESCALE = 16'h0063,
  parameter int          POLL_MAX = 255
) (
  input  logic       wb_clk_i,
  input  logic       arst_n_i,
  input  logic       req_i,
  input  logic       req_rw_i,
  input  logic [6:0] dev_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       err_o,
  output logic [1:0] err_code_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);

  localparam logic [7:0] POLL_MAX_C = POLL_MAX[7:0];

  localparam logic [2:0] ADR_PRL = 3'd0;
  localparam logic [2:0] ADR_PRH = 3'd1;
  localparam logic [2:0] ADR_CTR = 3'd2;
  localparam logic [2:0] ADR_TXR = 3'd3;
  localparam logic [2:0] ADR_CR  = 3'd4;

  localparam logic [7:0] CR_STOP = 8'h40;
  localparam logic [7:0] CTR_EN  = 8'h80;

  localparam logic [1:0] CODE_NACK = 2'b01;
  localparam logic [1:0] CODE_AL   = 2'b10;
  localparam logic [1:0] CODE_TOUT = 2'b11;

  typedef enum logic [3:0] {
    INIT_PRL, INIT_PRH, INIT_CTR, IDLE, LD_TXR, LD_CR,
    POLL, CHECK, RD_RXR, ERR_STOP, ERR_POLL, DONE
  } state_e;

  state_e     state_q, state_d;
  logic       gap_q, gap_d;
  logic [1:0] phase_q, phase_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdat_q, wdat_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] code_q, code_d;
  logic       err_q, err_d;

  logic       acked;
  logic [7:0] cnt_inc;
  logic       poll_full;
  logic       data_phase;
  logic [7:0] txr_val;
  logic [7:0] cr_val;

  assign acked      = wb_cyc_o & wb_ack_i;
  assign cnt_inc    = (cnt_q == POLL_MAX_C) ? cnt_q : cnt_q + 8'd1;
  assign poll_full  = (cnt_inc == POLL_MAX_C);
  // The final read phase is master-NACKed, so RxACK there carries no error.
  assign data_phase = rw_q && (phase_q == 2'd3);

  always_comb begin
    case (phase_q)
      2'd0:    txr_val = {dev_q, 1'b0};
      2'd1:    txr_val = reg_q;
      2'd2:    txr_val = rw_q ? {dev_q, 1'b1} : wdat_q;
      default: txr_val = 8'h00;
    endcase
  end

  always_comb begin
    case (phase_q)
      2'd0:    cr_val = 8'h90;
      2'd1:    cr_val = 8'h10;
      2'd2:    cr_val = rw_q ? 8'h90 : 8'h50;
      default: cr_val = 8'h68;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= INIT_PRL;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_PRL: if (acked) state_d = INIT_PRH;
      INIT_PRH: if (acked) state_d = INIT_CTR;
      INIT_CTR: if (acked) state_d = IDLE;
      IDLE:     if (req_i) state_d = LD_TXR;
      LD_TXR:   if (acked) state_d = LD_CR;
      LD_CR:    if (acked) state_d = POLL;
      POLL: begin
        if (acked) begin
          if (!wb_dat_i[1])   state_d = CHECK;
          else if (poll_full) state_d = ERR_STOP;
        end
      end
      CHECK: begin
        if (sr_q[5])                        state_d = ERR_STOP;
        else if (sr_q[7] && !data_phase)    state_d = ERR_STOP;
        else if (data_phase)                state_d = RD_RXR;
        else if (phase_q == 2'd2 && !rw_q)  state_d = DONE;
        else if (phase_q == 2'd2)           state_d = LD_CR;
        else                                state_d = LD_TXR;
      end
      RD_RXR:   if (acked) state_d = DONE;
      ERR_STOP: if (acked) state_d = ERR_POLL;
      ERR_POLL: if (acked && (!wb_dat_i[1] || poll_full)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = INIT_PRL;
    endcase
  end

  always_comb begin
    wb_cyc_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = 3'd0;
    wb_dat_o = 8'h00;
    if (!gap_q) begin
      case (state_q)
        INIT_PRL: begin wb_cyc_o = 1'b1; wb_we_o = 1'b1; wb_adr_o = ADR_PRL; wb_dat_o = PRESCALE[7:0];  end
        INIT_PRH: begin wb_cyc_o = 1'b1; wb_we_o = 1'b1; wb_adr_o = ADR_PRH; wb_dat_o = PRESCALE[15:8]; end
        INIT_CTR: begin wb_cyc_o = 1'b1; wb_we_o = 1'b1; wb_adr_o = ADR_CTR; wb_dat_o = CTR_EN;         end
        LD_TXR:   begin wb_cyc_o = 1'b1; wb_we_o = 1'b1; wb_adr_o = ADR_TXR; wb_dat_o = txr_val;        end
        LD_CR:    begin wb_cyc_o = 1'b1; wb_we_o = 1'b1; wb_adr_o = ADR_CR;  wb_dat_o = cr_val;         end
        ERR_STOP: begin wb_cyc_o = 1'b1; wb_we_o = 1'b1; wb_adr_o = ADR_CR;  wb_dat_o = CR_STOP;        end
        POLL, ERR_POLL: begin wb_cyc_o = 1'b1; wb_adr_o = ADR_CR;  end
        RD_RXR:         begin wb_cyc_o = 1'b1; wb_adr_o = ADR_TXR; end
        default: ;
      endcase
    end
    wb_stb_o   = wb_cyc_o;
    busy_o     = (state_q != IDLE) && (state_q != DONE);
    done_o     = (state_q == DONE);
    rdata_o    = rdata_q;
    err_o      = err_q;
    err_code_o = err_q ? code_q : 2'b00;
  end

  always_comb begin
    gap_d   = acked;
    phase_d = phase_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdat_d  = wdat_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          rw_d    = req_rw_i;
          dev_d   = dev_addr_i;
          reg_d   = reg_addr_i;
          wdat_d  = wdata_i;
          phase_d = 2'd0;
          err_d   = 1'b0;
          code_d  = 2'b00;
        end
      end
      LD_CR, ERR_STOP: if (acked) cnt_d = 8'd0;
      POLL: begin
        if (acked) begin
          cnt_d = cnt_inc;
          sr_d  = wb_dat_i;
          if (wb_dat_i[1] && poll_full) code_d = CODE_TOUT;
        end
      end
      CHECK: begin
        if (sr_q[5])                     code_d  = CODE_AL;
        else if (sr_q[7] && !data_phase) code_d  = CODE_NACK;
        else if (!data_phase)            phase_d = phase_q + 2'd1;
      end
      RD_RXR: if (acked) rdata_d = wb_dat_i;
      // A stop-poll timeout ends the transaction but keeps the original error code.
      ERR_POLL: begin
        if (acked) begin
          cnt_d = cnt_inc;
          if (!wb_dat_i[1] || poll_full) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      gap_q   <= 1'b1;
      phase_q <= 2'd0;
      rw_q    <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'h00;
      wdat_q  <= 8'h00;
      cnt_q   <= 8'd0;
      sr_q    <= 8'h00;
      rdata_q <= 8'h00;
      code_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      phase_q <= phase_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdat_q  <= wdat_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Directed bench: zero-wait Wishbone I2C core model with scripted TIP/AL/RxACK status and a bus-write log.
module tb_i2c_wb_sequencer;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       req, req_rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, wdata;
  logic       busy, done, err;
  logic [7:0] rdata;
  logic [1:0] err_code;
  logic [2:0] wb_adr;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_we, wb_stb, wb_cyc, wb_ack;

  i2c_wb_sequencer #(.PRESCALE(16'h0063), .POLL_MAX(4)) dut (
    .wb_clk_i(clk), .arst_n_i(arst_n), .req_i(req), .req_rw_i(req_rw),
    .dev_addr_i(dev_addr), .reg_addr_i(reg_addr), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .rdata_o(rdata), .err_o(err), .err_code_o(err_code),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we),
    .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_ack_i(wb_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // core model
  int         tip_load = 0;
  int         tip_left = 0;
  logic       tip_stuck = 1'b0, sr_al = 1'b0, sr_nack = 1'b0;
  logic [7:0] rxr = 8'h00;

  assign wb_ack = wb_cyc & wb_stb;

  always_comb begin
    wb_dat_i = 8'h00;
    if (wb_adr == 3'd4)
      wb_dat_i = {sr_nack, 1'b0, sr_al, 3'b000, (tip_stuck || tip_left != 0), 1'b0};
    else if (wb_adr == 3'd3)
      wb_dat_i = rxr;
  end

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && wb_ack && wb_adr == 3'd4) begin
      if (wb_we)              tip_left <= tip_load;
      else if (tip_left != 0) tip_left <= tip_left - 1;
    end
  end

  // bus monitor
  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];
  int   sr_reads = 0, rxr_reads = 0, sr_at_stop = -1, done_cnt = 0;
  logic last_err = 1'b0;
  logic [1:0] last_code = 2'b00;

  always @(negedge clk) begin
    if (wb_cyc && wb_stb && wb_ack) begin
      if (wb_we) begin
        log_q.push_back({wb_adr, wb_dat_o});
        if (wb_adr == 3'd4 && wb_dat_o == 8'h40) sr_at_stop = sr_reads;
      end else if (wb_adr == 3'd4) sr_reads++;
      else rxr_reads++;
    end
    if (done) begin
      done_cnt++;
      last_err  = err;
      last_code = err_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_nwr"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), {21'd0, log_q[i]}, {21'd0, exp_q[i]});
  endtask

  task automatic clear_mon();
    log_q.delete();
    exp_q.delete();
    sr_reads = 0; rxr_reads = 0; sr_at_stop = -1; done_cnt = 0;
  endtask

  task automatic exp_w(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 200) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 300) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    else          chk({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_req(input string tag, input logic rw, input logic [6:0] d,
                        input logic [7:0] r, input logic [7:0] w);
    @(negedge clk);
    req = 1'b1; req_rw = rw; dev_addr = d; reg_addr = r; wdata = w;
    @(negedge clk);
    req = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_err_clr"}, {err, err_code}, 3'b000);
  endtask

  task automatic exp_init();
    exp_w(3'd0, 8'h63); exp_w(3'd1, 8'h00); exp_w(3'd2, 8'h80);
  endtask

  initial begin
    arst_n = 1'b0; req = 1'b0; req_rw = 1'b0; dev_addr = '0; reg_addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_outs", {done, err, err_code, rdata, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o},
        30'd0);

    // init
    arst_n = 1'b1;
    wait_idle("init");
    exp_init();
    chk_log("init");
    chk("init_done_cnt", done_cnt, 0);

    // register write, TIP busy for 3 polls per phase
    clear_mon(); tip_load = 3;
    do_req("wr", 1'b0, 7'h50, 8'h12, 8'hA5);
    wait_done("wr");
    exp_w(3'd3, 8'hA0); exp_w(3'd4, 8'h90); exp_w(3'd3, 8'h12);
    exp_w(3'd4, 8'h10); exp_w(3'd3, 8'hA5); exp_w(3'd4, 8'h50);
    chk_log("wr");
    chk("wr_sr_reads", sr_reads, 12);
    chk("wr_err", {last_err, last_code}, 3'b000);
    chk("wr_done_cnt", done_cnt, 1);

    // register read with repeated start
    clear_mon(); tip_load = 1; rxr = 8'h3C;
    do_req("rd", 1'b1, 7'h50, 8'h04, 8'h00);
    wait_done("rd");
    exp_w(3'd3, 8'hA0); exp_w(3'd4, 8'h90); exp_w(3'd3, 8'h04); exp_w(3'd4, 8'h10);
    exp_w(3'd3, 8'hA1); exp_w(3'd4, 8'h90); exp_w(3'd4, 8'h68);
    chk_log("rd");
    chk("rd_rdata", rdata, 8'h3C);
    chk("rd_rxr_reads", rxr_reads, 1);
    chk("rd_sr_reads", sr_reads, 8);
    chk("rd_err", {last_err, last_code}, 3'b000);

    // address NACK
    clear_mon(); tip_load = 0; sr_nack = 1'b1; rxr = 8'h77;
    do_req("nack", 1'b1, 7'h50, 8'h04, 8'h00);
    wait_done("nack");
    exp_w(3'd3, 8'hA0); exp_w(3'd4, 8'h90); exp_w(3'd4, 8'h40);
    chk_log("nack");
    chk("nack_code", {last_err, last_code}, 3'b101);
    chk("nack_sr_at_stop", sr_at_stop, 1);
    repeat (5) @(negedge clk);
    chk("nack_err_hold", {err, err_code}, 3'b101);
    chk("nack_rdata_hold", rdata, 8'h3C);

    // arbitration lost together with NACK
    clear_mon(); sr_al = 1'b1;
    do_req("al", 1'b0, 7'h50, 8'h12, 8'hA5);
    wait_done("al");
    exp_w(3'd3, 8'hA0); exp_w(3'd4, 8'h90); exp_w(3'd4, 8'h40);
    chk_log("al");
    chk("al_code", {last_err, last_code}, 3'b110);

    // TIP stuck: timeout, stop-poll timeout keeps code 11, request while busy ignored
    clear_mon(); sr_al = 1'b0; sr_nack = 1'b0; tip_stuck = 1'b1;
    do_req("tout", 1'b0, 7'h50, 8'h12, 8'hA5);
    repeat (3) @(negedge clk);
    req = 1'b1; req_rw = 1'b0; dev_addr = 7'h11; reg_addr = 8'h22; wdata = 8'h33;
    @(negedge clk);
    req = 1'b0;
    wait_done("tout");
    exp_w(3'd3, 8'hA0); exp_w(3'd4, 8'h90); exp_w(3'd4, 8'h40);
    chk("tout_sr_at_stop", sr_at_stop, 4);
    chk("tout_sr_reads", sr_reads, 8);
    chk("tout_code", {last_err, last_code}, 3'b111);
    repeat (10) @(negedge clk);
    chk_log("tout");
    chk("tout_done_cnt", done_cnt, 1);
    chk("tout_idle", busy, 1'b0);

    // reset during a read's status poll
    clear_mon(); tip_stuck = 1'b0; tip_load = 3;
    do_req("mrst", 1'b1, 7'h50, 8'h04, 8'h00);
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        if (wb_cyc && !wb_we && wb_adr == 3'd4) break;
        @(negedge clk);
      end
      if (i == 100) chk("mrst_poll_timeout", 32'd0, 32'd1);
    end
    #1 arst_n = 1'b0;
    #1 chk("mrst_cyc_drop", {wb_cyc, wb_stb}, 2'b00);
    chk("mrst_busy", busy, 1'b1);
    clear_mon();
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    wait_idle("mrst");
    exp_init();
    chk_log("mrst");
    chk("mrst_done_cnt", done_cnt, 0);
    chk("mrst_rdata", rdata, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
